servo_ramp_scheduler: RTL and testbench

- APB3 slave that sequences the x/y servo PWM generator: software writes target pulse widths, and the block slews current widths toward them by a programmable step once per PWM frame.
- Publishes the current widths plus a one-cycle update strobe to the PWM generator's width inputs, and raises a done interrupt when both axes reach target.
- Sits between the processor APB fabric and the servo PWM generator and prevents instantaneous servo jumps.

---
 rtl/servo_ramp_scheduler_if.sv | 23 ++
 rtl/servo_ramp_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_servo_ramp_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_ramp_scheduler_if.sv
// APB3 bus bundle between the processor fabric and the servo ramp scheduler.
// No latency of its own; it only groups wires.
// No backpressure: the slave drives PREADY high permanently.
interface servo_ramp_scheduler_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/servo_ramp_scheduler.sv
// Slews x/y servo pulse widths toward software targets by a fixed step once per PWM frame.
// Latency: frame tick in T, x step in T+1, y step in T+2, widths and width_update appear in T+3.
// No backpressure: APB completes in zero wait states and width_update is a fire-and-forget strobe.
module servo_ramp_scheduler #(
    parameter int unsigned FRAME_CYCLES = 2000000,
    parameter int unsigned MIN_WIDTH    = 100000,
    parameter int unsigned MAX_WIDTH    = 200000,
    parameter int unsigned RESET_WIDTH  = 150000,
    parameter int unsigned DEFAULT_STEP = 1000
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    servo_ramp_scheduler_if.slave       apb,
    output logic [31:0]                 x_width,
    output logic [31:0]                 y_width,
    output logic                        width_update,
    output logic                        busy,
    output logic                        irq_done
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
    localparam logic [31:0] MIN_W   = 32'(MIN_WIDTH);
    localparam logic [31:0] MAX_W   = 32'(MAX_WIDTH);
    localparam logic [31:0] RESET_W = 32'(RESET_WIDTH);
    localparam logic [31:0] RESET_S = 32'(DEFAULT_STEP);

    localparam logic [12:0] ADDR_X_TARGET = 13'h100;
    localparam logic [12:0] ADDR_Y_TARGET = 13'h104;
    localparam logic [12:0] ADDR_STEP     = 13'h108;
    localparam logic [12:0] ADDR_CTRL     = 13'h10C;
    localparam logic [12:0] ADDR_X_WIDTH  = 13'h110;
    localparam logic [12:0] ADDR_Y_WIDTH  = 13'h114;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        STEP_X,
        STEP_Y,
        PUBLISH
    } state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          tick;
    logic [31:0]   x_target;
    logic [31:0]   y_target;
    logic [31:0]   step;
    logic          enable;
    logic [31:0]   x_work;
    logic [31:0]   y_work;
    logic [31:0]   x_next;
    logic [31:0]   y_next;
    logic [12:0]   addr;
    logic          wr_en;
    logic          irq_clr;
    logic          unused_addr_bits;

    // Keep any stored target inside the mechanically safe pulse range.
    function automatic logic [31:0] clamp_width(input logic [31:0] v);
        if (v < MIN_W) begin
            return MIN_W;
        end else if (v > MAX_W) begin
            return MAX_W;
        end
        return v;
    endfunction

    // One slew step: land on target when close enough (or step is zero), else move by step.
    // The 33-bit signed difference keeps the direction test free of wraparound.
    function automatic logic [31:0] slew(input logic [31:0] cur,
                                         input logic [31:0] tgt,
                                         input logic [31:0] stp);
        logic signed [32:0] diff;
        logic        [32:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[32] ? 33'(-diff) : 33'(diff);
        if ((stp == 32'd0) || (mag <= {1'b0, stp})) begin
            return tgt;
        end else if (diff[32]) begin
            return cur - stp;
        end
        return cur + stp;
    endfunction

    assign addr             = apb.PADDR[12:0];
    assign unused_addr_bits = ^apb.PADDR[31:13];
    assign wr_en            = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign irq_clr          = wr_en && (addr == ADDR_CTRL) && apb.PWDATA[1];
    assign tick             = (frame_cnt == LAST_COUNT);
    assign x_next           = slew(x_work, x_target, step);
    assign y_next           = slew(y_work, y_target, step);
    assign busy             = (state != IDLE);
    assign apb.PREADY       = 1'b1;
    assign apb.PSLVERR      = 1'b0;

    // Free-running frame counter aligned to the PWM generator period.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Software-visible configuration registers; a target written while stepping is seen next frame.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            x_target <= RESET_W;
            y_target <= RESET_W;
            step     <= RESET_S;
            enable   <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                ADDR_X_TARGET: x_target <= clamp_width(apb.PWDATA);
                ADDR_Y_TARGET: y_target <= clamp_width(apb.PWDATA);
                ADDR_STEP:     step     <= apb.PWDATA;
                ADDR_CTRL:     enable   <= apb.PWDATA[0];
                default:       ;
            endcase
        end
    end

    // Ramp sequencer: one x step and one y step per frame, then a single publish cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state        <= IDLE;
            x_work       <= RESET_W;
            y_work       <= RESET_W;
            x_width      <= RESET_W;
            y_width      <= RESET_W;
            width_update <= 1'b0;
            irq_done     <= 1'b0;
        end else begin
            width_update <= 1'b0;
            // A completing publish below overrides this clear in the same cycle.
            if (irq_clr) begin
                irq_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable && ((x_work != x_target) || (y_work != y_target))) begin
                        state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        state <= STEP_X;
                    end
                end
                STEP_X: begin
                    x_work <= x_next;
                    state  <= STEP_Y;
                end
                STEP_Y: begin
                    y_work       <= y_next;
                    x_width      <= x_work;
                    y_width      <= y_next;
                    width_update <= 1'b1;
                    state        <= PUBLISH;
                end
                PUBLISH: begin
                    if ((x_work == x_target) && (y_work == y_target)) begin
                        irq_done <= 1'b1;
                        state    <= IDLE;
                    end else if (enable) begin
                        state <= WAIT_FRAME;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational read mux; unmapped addresses and non-read cycles return zero.
    always_comb begin
        apb.PRDATA = 32'd0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (addr)
                ADDR_X_TARGET: apb.PRDATA = x_target;
                ADDR_Y_TARGET: apb.PRDATA = y_target;
                ADDR_STEP:     apb.PRDATA = step;
                ADDR_CTRL:     apb.PRDATA = {29'd0, busy, irq_done, enable};
                ADDR_X_WIDTH:  apb.PRDATA = x_width;
                ADDR_Y_WIDTH:  apb.PRDATA = y_width;
                default:       apb.PRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Bench for servo_ramp_scheduler: directed scenarios with literal expectations, then random APB traffic.
// A frame-level reference model predicts widths, strobe, busy and irq each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or mid-cycle.
module tb_servo_ramp_scheduler;

    localparam int FRAME = 10;
    localparam longint RW = 150000;
    localparam longint WMIN = 100000;
    localparam longint WMAX = 200000;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] x_width;
    logic [31:0] y_width;
    logic        width_update;
    logic        busy;
    logic        irq_done;

    servo_ramp_scheduler_if bus ();

    servo_ramp_scheduler #(.FRAME_CYCLES(FRAME)) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .apb          (bus),
        .x_width      (x_width),
        .y_width      (y_width),
        .width_update (width_update),
        .busy         (busy),
        .irq_done     (irq_done)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // ---------------- reference model ----------------
    // Register view plus where we are relative to the last frame tick.
    longint m_xt, m_yt, m_step, m_xw, m_yw, m_nx;
    bit     m_en, m_irq, m_ramp, m_upd;
    int     m_since;   // 0: waiting for a tick, 1..3: cycles since tick
    int     m_cnt;

    function automatic longint clampm(input longint v);
        if (v < WMIN) return WMIN;
        if (v > WMAX) return WMAX;
        return v;
    endfunction

    function automatic longint slewm(input longint cur, input longint tgt, input longint stp);
        longint d;
        longint a;
        d = tgt - cur;
        a = (d < 0) ? -d : d;
        if (stp == 0 || a <= stp) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic longint exp_read(input logic [31:0] a);
        case (a[12:0])
            13'h100: return m_xt;
            13'h104: return m_yt;
            13'h108: return m_step;
            13'h10C: return (m_ramp ? 4 : 0) + (m_irq ? 2 : 0) + (m_en ? 1 : 0);
            13'h110: return m_xw;
            13'h114: return m_yw;
            default: return 0;
        endcase
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_xt = RW; m_yt = RW; m_step = 1000; m_xw = RW; m_yw = RW; m_nx = RW;
            m_en = 0; m_irq = 0; m_ramp = 0; m_upd = 0; m_since = 0; m_cnt = 0;
        end else begin : model_step
            bit wr;
            bit done_now;
            logic [12:0] a;
            wr = bus.PSEL && bus.PENABLE && bus.PWRITE;
            a = bus.PADDR[12:0];
            done_now = 0;
            m_upd = 0;
            if (!m_ramp) begin
                if (m_en && (m_xw != m_xt || m_yw != m_yt)) begin
                    m_ramp = 1;
                    m_since = 0;
                end
            end else begin
                case (m_since)
                    0: begin
                        if (!m_en) m_ramp = 0;
                        else if (m_cnt == FRAME - 1) m_since = 1;
                    end
                    1: begin
                        m_nx = slewm(m_xw, m_xt, m_step);
                        m_since = 2;
                    end
                    2: begin
                        m_xw = m_nx;
                        m_yw = slewm(m_yw, m_yt, m_step);
                        m_since = 3;
                        m_upd = 1;
                    end
                    default: begin
                        if (m_xw == m_xt && m_yw == m_yt) begin
                            done_now = 1;
                            m_ramp = 0;
                        end else if (m_en) begin
                            m_since = 0;
                        end else begin
                            m_ramp = 0;
                        end
                    end
                endcase
            end
            if (wr) begin
                case (a)
                    13'h100: m_xt = clampm(longint'(bus.PWDATA));
                    13'h104: m_yt = clampm(longint'(bus.PWDATA));
                    13'h108: m_step = longint'(bus.PWDATA);
                    13'h10C: begin
                        m_en = bus.PWDATA[0];
                        if (bus.PWDATA[1]) m_irq = 0;
                    end
                    default: ;
                endcase
            end
            if (done_now) m_irq = 1;
            m_cnt = (m_cnt + 1) % FRAME;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge PCLK) begin
        if (checking && !PRESET) begin
            checks++;
            if (longint'(x_width) != m_xw || longint'(y_width) != m_yw || width_update != m_upd ||
                busy != m_ramp || irq_done != m_irq) begin
                errors++;
                $display("FAIL outputs t=%0t x=%0d req %0d y=%0d req %0d upd=%0b req %0b busy=%0b req %0b irq=%0b req %0b",
                         $time, x_width, m_xw, y_width, m_yw, width_update, m_upd, busy, m_ramp, irq_done, m_irq);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        bus.PSEL = 1; bus.PWRITE = 1; bus.PENABLE = 0; bus.PADDR = addr; bus.PWDATA = data;
        cycles(1);
        bus.PENABLE = 1;
        cycles(1);
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output longint exp);
        bus.PSEL = 1; bus.PWRITE = 0; bus.PENABLE = 0; bus.PADDR = addr;
        cycles(1);
        bus.PENABLE = 1;
        #2;
        data = bus.PRDATA;
        exp = exp_read(addr);
        cycles(1);
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    task automatic wait_update(input int budget, output logic [31:0] xv, output logic [31:0] yv);
        bit found;
        found = 0;
        xv = 0;
        yv = 0;
        for (int n = 0; n < budget && !found; n++) begin
            cycles(1);
            if (width_update) begin
                found = 1;
                xv = x_width;
                yv = y_width;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_update: no strobe within %0d cycles", budget);
        end
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'($urandom_range(0, 300000));
        if (sel == 1) return 32'(WMIN);
        if (sel == 2) return 32'(WMAX);
        return 32'($urandom_range(140000, 160000));
    endfunction

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] rd, xv, yv, addr, data;
        longint ev;
        int pulses;
        logic [31:0] exp_x [4];

        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        PRESET = 1;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 0;
        checking = 1;

        // Reset state
        apb_read(32'h110, rd, ev); check("reset_x_width", rd, 150000);
        apb_read(32'h114, rd, ev); check("reset_y_width", rd, 150000);
        apb_read(32'h10C, rd, ev); check("reset_ctrl", rd, 0);
        apb_read(32'h108, rd, ev); check("reset_step", rd, 1000);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cycles(1);
            if (width_update) pulses++;
        end
        check("no_update_while_disabled", pulses, 0);

        // Basic ramp on x only
        apb_write(32'h100, 32'd153500);
        apb_write(32'h10C, 32'h1);
        exp_x[0] = 151000; exp_x[1] = 152000; exp_x[2] = 153000; exp_x[3] = 153500;
        for (int i = 0; i < 4; i++) begin
            wait_update(4 * FRAME, xv, yv);
            check($sformatf("ramp_x_%0d", i), xv, exp_x[i]);
            check($sformatf("ramp_y_%0d", i), yv, 150000);
        end
        cycles(1);
        check("ramp_irq_set", irq_done, 1);
        check("ramp_busy_low", busy, 0);

        // Clamping and zero step
        apb_write(32'h10C, 32'h2);
        apb_write(32'h100, 32'd50000);
        apb_write(32'h104, 32'd300000);
        apb_read(32'h100, rd, ev); check("clamp_low", rd, 100000);
        apb_read(32'h104, rd, ev); check("clamp_high", rd, 200000);
        apb_write(32'h108, 32'd0);
        apb_write(32'h10C, 32'h1);
        wait_update(4 * FRAME, xv, yv);
        check("step0_x", xv, 100000);
        check("step0_y", yv, 200000);
        cycles(1);
        check("step0_irq", irq_done, 1);
        pulses = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycles(1);
            if (width_update) pulses++;
        end
        check("step0_single_publish", pulses, 0);

        // Return to centre, then retarget mid-ramp
        apb_write(32'h10C, 32'h2);
        apb_write(32'h100, 32'd150000);
        apb_write(32'h104, 32'd150000);
        apb_write(32'h10C, 32'h1);
        wait_update(4 * FRAME, xv, yv);
        check("recentre_x", xv, 150000);
        apb_write(32'h10C, 32'h2);
        apb_write(32'h108, 32'd1000);
        apb_write(32'h100, 32'd153500);
        apb_write(32'h10C, 32'h1);
        xv = 0;
        for (int i = 0; i < 3 && xv != 152000; i++) wait_update(4 * FRAME, xv, yv);
        check("retarget_reach_152000", xv, 152000);
        apb_write(32'h100, 32'd150500);
        wait_update(4 * FRAME, xv, yv);
        check("retarget_first", xv, 151000);
        wait_update(4 * FRAME, xv, yv);
        check("retarget_second", xv, 150500);
        cycles(1);
        check("retarget_irq", irq_done, 1);

        // irq clear coinciding with a completing publish: set wins
        apb_write(32'h10C, 32'h3);
        check("irq_cleared", irq_done, 0);
        apb_write(32'h100, 32'd151000);
        pulses = 0;
        for (int i = 0; i < 4 * FRAME && !(m_ramp && m_since == 2); i++) begin
            cycles(1);
            pulses++;
        end
        check("reached_step_y", (m_ramp && m_since == 2) ? 1 : 0, 1);
        apb_write(32'h10C, 32'h3);
        check("irq_set_wins", irq_done, 1);
        apb_write(32'h10C, 32'h2);
        check("irq_later_clear", irq_done, 0);

        // Asynchronous reset mid-ramp
        apb_write(32'h100, 32'd160000);
        apb_write(32'h10C, 32'h1);
        wait_update(4 * FRAME, xv, yv);
        check("pre_reset_x", xv, 152000);
        cycles(4);
        #2;
        PRESET = 1;
        #1;
        check("areset_x", x_width, 150000);
        check("areset_y", y_width, 150000);
        check("areset_upd", width_update, 0);
        check("areset_busy", busy, 0);
        check("areset_irq", irq_done, 0);
        @(posedge PCLK);
        #1;
        PRESET = 0;
        apb_read(32'h100, rd, ev); check("areset_x_target", rd, 150000);
        apb_read(32'h10C, rd, ev); check("areset_ctrl", rd, 0);

        // Random traffic against the model
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1: apb_write(32'h100, rand_target());
                2, 3: apb_write(32'h104, rand_target());
                4: apb_write(32'h108, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(200, 6000)));
                5: begin
                    data = 32'(($urandom_range(0, 3) != 0) ? 1 : 0) | 32'($urandom_range(0, 1) << 1);
                    apb_write(32'h10C, data);
                end
                6: apb_write(32'($urandom_range(0, 15) << 13) | 32'h118, $urandom);
                7, 8: begin
                    case ($urandom_range(0, 9))
                        0: addr = 32'h100; 1: addr = 32'h104; 2: addr = 32'h108;
                        3: addr = 32'h10C; 4: addr = 32'h110; 5: addr = 32'h114;
                        6: addr = 32'h118; 7: addr = 32'h000; 8: addr = 32'h1100;
                        default: addr = 32'h0FC;
                    endcase
                    addr = addr | 32'($urandom_range(0, 255) << 13);
                    apb_read(addr, rd, ev);
                    check($sformatf("rand_read_%0h", addr), rd, ev);
                end
                default: cycles($urandom_range(1, 40));
            endcase
        end
        cycles(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
